mem_req_ctrl: RTL and testbench

//  Request front-end that sits directly upstream of the 1 KiB mem block and drives its clk/write/read/addr/wrdata/rddata port.

---
 rtl/mem_req_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Load/store request front-end for the 1 KiB word memory: sub-word stores become read-modify-write.
// Optional MEM_INIT_EN: zero-fill the memory after reset before the first request is accepted.
module mem_req_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wrdata,
    input  logic [31:0]       mem_rddata,
    output logic [CNT_W-1:0]  done_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RSP    = 3'd5,
        ST_INIT   = 3'd6
    } state_t;

`ifdef MEM_INIT_EN
    localparam state_t ST_RESET = ST_INIT;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lo[0];
            2'd2:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn);
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{sgn & word[7]}}, word[7:0]};
            2'd1:    res = {{16{sgn & word[15]}}, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Store data is LSB-aligned; a half store uses lane pair addr[1], a byte store lane addr[1:0].
    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            2'd1: begin
                if (lane[1]) res[31:16] = wd;
                else         res[15:0]  = wd;
            end
            default: res = word;
        endcase
        return res;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          size_r;
    logic                signed_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [15:0]         wdata_r;
    logic                req_ready_r;
    logic                rsp_valid_r, rsp_valid_s;
    logic [31:0]         rsp_rdata_r, rsp_rdata_s;
    logic                rsp_err_r, rsp_err_s;
    logic                mem_write_r, mem_write_s;
    logic                mem_read_r, mem_read_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [31:0]         mem_wrdata_r, mem_wrdata_s;
    logic [CNT_W-1:0]    done_cnt_r;
    logic                accept_s, handoff_s;
`ifdef MEM_INIT_EN
    logic [ADDR_W-3:0]   init_cnt_r, init_cnt_s;
`endif

    // Next-state logic; memory and response outputs are computed one edge early and registered.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        handoff_s    = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_addr_s   = {ADDR_W{1'b0}};
        mem_wrdata_s = 32'd0;
        rsp_valid_s  = rsp_valid_r;
        rsp_rdata_s  = rsp_rdata_r;
        rsp_err_s    = rsp_err_r;
`ifdef MEM_INIT_EN
        init_cnt_s   = init_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (req_bad(req_size, req_addr[1:0])) begin
                        state_s     = ST_RSP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = 32'd0;
                    end else if (!req_we) begin
                        state_s    = ST_LOAD;
                        mem_read_s = 1'b1;
                        mem_addr_s = req_addr;
                    end else if (req_size == 2'd2) begin
                        state_s      = ST_STORE;
                        mem_write_s  = 1'b1;
                        mem_addr_s   = req_addr;
                        mem_wrdata_s = req_wdata;
                    end else begin
                        state_s    = ST_RMW_RD;
                        mem_read_s = 1'b1;
                        mem_addr_s = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s     = ST_RSP;
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b0;
                rsp_rdata_s = extend_load(mem_rddata, size_r, signed_r);
            end
            ST_RMW_RD: begin
                state_s      = ST_RMW_WR;
                mem_write_s  = 1'b1;
                mem_addr_s   = {addr_r[ADDR_W-1:2], 2'b00};
                mem_wrdata_s = merge_lane(mem_rddata, wdata_r, size_r, addr_r[1:0]);
            end
            ST_STORE, ST_RMW_WR: begin
                state_s     = ST_RSP;
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b0;
                rsp_rdata_s = 32'd0;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    handoff_s   = 1'b1;
                    rsp_valid_s = 1'b0;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = 32'd0;
                end else begin
                    state_s = ST_RSP;
                end
            end
`ifdef MEM_INIT_EN
            // First INIT cycle only primes the write; each later edge lands word init_cnt_r.
            ST_INIT: begin
                if (!mem_write_r) begin
                    mem_write_s = 1'b1;
                    mem_addr_s  = {init_cnt_r, 2'b00};
                end else if (init_cnt_r == {(ADDR_W-2){1'b1}}) begin
                    state_s    = ST_IDLE;
                    init_cnt_s = {(ADDR_W-2){1'b0}};
                end else begin
                    init_cnt_s  = init_cnt_r + {{(ADDR_W-3){1'b0}}, 1'b1};
                    mem_write_s = 1'b1;
                    mem_addr_s  = {init_cnt_s, 2'b00};
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request, registered outputs and handoff counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RESET;
            size_r       <= 2'd0;
            signed_r     <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= 16'd0;
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'd0;
            rsp_err_r    <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wrdata_r <= 32'd0;
            done_cnt_r   <= {CNT_W{1'b0}};
`ifdef MEM_INIT_EN
            init_cnt_r   <= {(ADDR_W-2){1'b0}};
`endif
        end else begin
            state_r      <= state_s;
            req_ready_r  <= (state_s == ST_IDLE);
            rsp_valid_r  <= rsp_valid_s;
            rsp_rdata_r  <= rsp_rdata_s;
            rsp_err_r    <= rsp_err_s;
            mem_write_r  <= mem_write_s;
            mem_read_r   <= mem_read_s;
            mem_addr_r   <= mem_addr_s;
            mem_wrdata_r <= mem_wrdata_s;
`ifdef MEM_INIT_EN
            init_cnt_r   <= init_cnt_s;
`endif
            if (accept_s) begin
                size_r   <= req_size;
                signed_r <= req_signed;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata[15:0];
            end
            if (handoff_s) begin
                done_cnt_r <= done_cnt_r + CNT_ONE;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign mem_write  = mem_write_r;
    assign mem_read   = mem_read_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wrdata = mem_wrdata_r;
    assign done_cnt   = done_cnt_r;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: byte-array memory, byte-level reference model and response scoreboard.
// Define MEM_INIT_EN for both bench and RTL to cover the zero-fill sweep.
module tb_mem_req_ctrl;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_write, mem_read;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wrdata, mem_rddata;
    logic [3:0]  done_cnt;

    mem_req_ctrl #(.ADDR_W(10), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata),
        .done_cnt(done_cnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  phys[0:1023];
    logic [7:0]  ref_mem[0:1023];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          hold_low = 1'b0;
    bit          preloaded = 1'b0;
    bit          seen = 1'b0;
    logic [3:0]  exp_done = 4'd0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory model: combinational little-endian read, word write at the edge.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) phys[i] = pat(i);
            preloaded = 1'b1;
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++) phys[10'(mem_addr + 10'(i))] = mem_wrdata[8*i +: 8];
        end
    end

    always_comb begin
        logic [9:0] a;
        a = mem_addr;
        mem_rddata = {phys[a + 10'd3], phys[a + 10'd2], phys[a + 10'd1], phys[a]};
    end

    always @(posedge clk) begin
        #1;
        rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Reference model: operates on bytes, independent of the controller's state sequence.
    task automatic model(input bit we, input bit [1:0] size, input bit sgn, input bit [9:0] addr,
                         input bit [31:0] wd, output exp_t e);
        int     nb;
        longint v;
        nb = 1 << size;
        e.acc = cyc + 1;
        e.rdata = 32'd0;
        e.err = 1'b0;
        if (size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
            e.lat = (size == 2'd2) ? 2 : 3;
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[addr + i]) << (8 * i));
            if (sgn && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
            e.rdata = v[31:0];
            e.lat = 2;
        end
    endtask

    task automatic do_req(input bit we, input bit [1:0] size, input bit sgn, input bit [9:0] addr,
                          input bit [31:0] wd, input bit apply);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                if (apply) begin
                    model(we, size, sgn, addr, wd, e);
                    q.push_back(e);
                end
            end
        end
        if (!got) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (q.size() != 0 || rsp_valid); i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_ready(input int exp_writes);
        int w;
        w = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) break;
            if (mem_write) w++;
        end
        chk("init_writes", 32'(w), 32'(exp_writes));
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    endtask

    // Scoreboard monitor: bus invariants every cycle, response latency and payload at handoff.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            exp_done = 4'd0;
        end else begin
            if (mem_read && mem_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
            if (!mem_read && !mem_write && (mem_addr != 10'd0 || mem_wrdata != 32'd0))
                chk("idle_bus_zero", {mem_addr, mem_wrdata[21:0]}, 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                    end
                    if (rsp_ready) begin
                        chk("rsp_rdata", rsp_rdata, q[0].rdata);
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
                        chk("done_cnt", {28'd0, done_cnt}, {28'd0, exp_done});
                        exp_done = exp_done + 4'd1;
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [3:0]  done0;
        int          init_w;
        bit [9:0]    a;
        bit [1:0]    sz;
        int          r;
`ifdef MEM_INIT_EN
        init_w = 256;
`else
        init_w = 0;
`endif
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 10'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_err, mem_read, mem_write, done_cnt, mem_addr},
            32'd0);
        chk("reset_data", rsp_rdata | mem_wrdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
`ifdef MEM_INIT_EN
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
`endif
        wait_ready(init_w);
`ifdef MEM_INIT_EN
        for (int i = 0; i < 8; i++) do_req(1'b0, 2'd2, 1'b0, 10'($urandom_range(0, 255) * 4), 32'd0, 1'b1);
`endif

        // Word store / load, sub-word RMW, signed byte, misaligned half, top word.
        do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 1'b1);
        do_req(1'b1, 2'd0, 1'b0, 10'h013, 32'h000000AB, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 10'h013, 32'd0, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 10'h011, 32'd0, 1'b1);
        chk("err_no_mem_access", {30'd0, mem_read, mem_write}, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 10'h3FE, 32'h0000C3D2, 1'b1);
        do_req(1'b0, 2'd2, 1'b1, 10'h3FC, 32'd0, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 10'h3FE, 32'd0, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 10'h3FF, 32'd0, 1'b1);
        wait_drain();

        // Response back-pressure: response held stable, no new acceptance, no count.
        hold_low = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 1'b1);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        held = rsp_rdata;
        done0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_cnt", {28'd0, done_cnt}, {28'd0, done0});
        end
        hold_low = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("cnt_after_handoff", {28'd0, done_cnt}, {28'd0, done0 + 4'd1});

        // Reset while the read half of a byte store is in flight.
        do_req(1'b1, 2'd0, 1'b0, 10'h021, 32'h0000005A, 1'b0);
        chk("in_rmw_rd", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {req_ready, rsp_valid, rsp_err, mem_read, mem_write, done_cnt, mem_addr},
            32'd0);
        chk("async_reset_data", mem_wrdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
`ifdef MEM_INIT_EN
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
`endif
        wait_ready(init_w);
        do_req(1'b0, 2'd2, 1'b0, 10'h020, 32'd0, 1'b1);
        wait_drain();

        // Random traffic concentrated on two small windows so stores and loads overlap.
        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 1) != 0) ? 10'h3E0 : 10'h000;
            a = a + 10'($urandom_range(0, 31));
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
        end
        wait_drain();
        chk("final_done_cnt", {28'd0, done_cnt}, {28'd0, exp_done});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
